alert_handler_class_sched: RTL

ALERT_HANDLER_CLASS_SCHED -- requirements
Module: alert_handler_class_sched

---
 rtl/alert_handler_class_sched.sv | 176 +++++++++++++++++
 1 files changed

// File: rtl/alert_handler_class_sched.sv
// Alert class scheduler: per-class saturating trigger counters with a
// round-robin service request/acknowledge handshake toward escalation.
module alert_handler_class_sched #(
    parameter int unsigned NClasses = 4,
    parameter int unsigned CntW     = 16
) (
    input  logic                        clk_i,
    input  logic                        rst_i,
    input  logic [NClasses-1:0]         class_trig_i,
    input  logic [NClasses-1:0]         class_en_i,
    input  logic [NClasses-1:0]         clr_i,
    output logic                        svc_req_o,
    output logic [$clog2(NClasses)-1:0] svc_class_o,
    output logic [CntW-1:0]             svc_cnt_o,
    input  logic                        svc_ack_i,
    output logic [NClasses-1:0]         pending_o,
    output logic [NClasses-1:0]         overflow_o
);

    localparam int unsigned     IdxW   = $clog2(NClasses);
    localparam logic [CntW-1:0] CntMax = '1;

    typedef enum logic {
        IDLE,
        REQ
    } state_e;

    state_e                state_q, state_d;
    logic [CntW-1:0]       cnt_q [NClasses];
    logic [IdxW-1:0]       rr_ptr_q;
    logic [NClasses-1:0]   inc;
    logic [NClasses-1:0]   eligible;
    logic [NClasses-1:0]   others;
    logic                  ack_fire;
    logic                  drop;
    logic                  load_grant;
    logic [IdxW-1:0]       next_ptr;
    logic [NClasses-1:0]   search_vec;
    logic [IdxW-1:0]       search_start;
    logic [IdxW-1:0]       grant_idx;
    logic                  search_found;

    // Successor index with wrap from NClasses-1 back to 0
    function automatic logic [IdxW-1:0] wrap_inc(input logic [IdxW-1:0] i);
        if (i == IdxW'(NClasses - 1)) begin
            return '0;
        end
        return i + 1'b1;
    endfunction

    // Pending flags straight from the counter registers
    always_comb begin
        pending_o = '0;
        for (int unsigned k = 0; k < NClasses; k++) begin
            pending_o[k] = (cnt_q[k] != '0);
        end
    end

    // Handshake qualifiers; a class being cleared this cycle is not offered,
    // so a grant never snapshots a count that is about to vanish
    always_comb begin
        inc                   = class_trig_i & class_en_i;
        eligible              = pending_o & ~clr_i;
        others                = eligible;
        others[svc_class_o]   = 1'b0;
        ack_fire              = (state_q == REQ) && svc_ack_i;
        drop                  = (state_q == REQ) && !svc_ack_i && clr_i[svc_class_o];
        next_ptr              = wrap_inc(svc_class_o);
    end

    // State register
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and grant selection control
    always_comb begin
        state_d      = state_q;
        load_grant   = 1'b0;
        search_vec   = eligible;
        search_start = rr_ptr_q;
        unique case (state_q)
            IDLE: begin
                if (|eligible) begin
                    state_d    = REQ;
                    load_grant = 1'b1;
                end
            end
            REQ: begin
                if (ack_fire) begin
                    search_vec   = others;
                    search_start = next_ptr;
                    if (|others) begin
                        load_grant = 1'b1;
                    end else begin
                        state_d = IDLE;
                    end
                end else if (drop) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Outputs decoded from state
    always_comb begin
        svc_req_o = (state_q == REQ);
    end

    // Round-robin search: first set bit of search_vec at or after search_start
    always_comb begin
        int unsigned idx;
        idx          = 0;
        grant_idx    = '0;
        search_found = 1'b0;
        for (int unsigned i = 0; i < NClasses; i++) begin
            idx = 32'(search_start) + i;
            if (idx >= NClasses) begin
                idx = idx - NClasses;
            end
            if (!search_found && search_vec[idx[IdxW-1:0]]) begin
                search_found = 1'b1;
                grant_idx    = idx[IdxW-1:0];
            end
        end
    end

    // Per-class counters and sticky overflow; clear dominates, and the ack
    // path subtracts the serviced snapshot while keeping concurrent triggers
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int unsigned k = 0; k < NClasses; k++) begin
                cnt_q[k] <= '0;
            end
            overflow_o <= '0;
        end else begin
            for (int unsigned k = 0; k < NClasses; k++) begin
                if (clr_i[k]) begin
                    cnt_q[k]      <= '0;
                    overflow_o[k] <= 1'b0;
                end else if (ack_fire && (svc_class_o == IdxW'(k))) begin
                    cnt_q[k] <= cnt_q[k] - svc_cnt_o + CntW'(inc[k]);
                end else if (inc[k]) begin
                    if (cnt_q[k] == CntMax) begin
                        overflow_o[k] <= 1'b1;
                    end else begin
                        cnt_q[k] <= cnt_q[k] + 1'b1;
                    end
                end
            end
        end
    end

    // Round-robin pointer and grant snapshot registers
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rr_ptr_q    <= '0;
            svc_class_o <= '0;
            svc_cnt_o   <= '0;
        end else begin
            if (ack_fire) begin
                rr_ptr_q <= next_ptr;
            end
            if (load_grant) begin
                svc_class_o <= grant_idx;
                svc_cnt_o   <= cnt_q[grant_idx];
            end
        end
    end

endmodule
